pressure_abnormality_monitor: RTL and testbench

Parametrised, clocked successor to the combinational pressure abnormality detector in the HealthCareSystem sensor path. It qualifies each valid pressure sample against programmable low and high thresholds. An alarm asserts only after `PERSIST` consecutive out-of-range samples, and clears only after `PERSIST` consecutive samples inside a hysteresis-narrowed safe band. The block sits between the pressure sensor sampler and the alarm/display aggregator, and also reports direction, an optional sticky alarm and a saturating episode count.

---
 rtl/pressure_abnormality_monitor.sv | 177 +++++++++++++++++
 tb/tb_pressure_abnormality_monitor.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pressure_abnormality_monitor.sv
// Pressure abnormality monitor: persistence-qualified high/low alarm with hysteresis.
// Optional sticky alarm enabled by defining PRESSURE_ALARM_LATCH_EN.
module pressure_abnormality_monitor #(
  parameter int WIDTH   = 6,
  parameter int LOW_TH  = 8,
  parameter int HIGH_TH = 42,
  parameter int HYST    = 2,
  parameter int PERSIST = 3,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] pressureData,
  input  logic             sampleValid,
  input  logic             alarmAck,
  output logic             pressureAbnormality,
  output logic             abnormalHigh,
  output logic             abnormalLow,
  output logic             alarmLatched,
  output logic [EVT_W-1:0] eventCount
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HIGH_TH);
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] SAFE_LO = WIDTH'(LOW_TH + HYST);
  localparam logic [WIDTH-1:0] SAFE_HI = WIDTH'(HIGH_TH - HYST);

  if (LOW_TH + HYST > HIGH_TH - HYST) begin : gBadBand
    $fatal(1, "safe band is empty");
  end
  if (PERSIST < 1) begin : gBadPersist
    $fatal(1, "PERSIST must be at least 1");
  end
  if (HIGH_TH >= (1 << WIDTH)) begin : gBadHigh
    $fatal(1, "HIGH_TH does not fit in WIDTH");
  end

  typedef enum logic [2:0] {
    NORMAL,
    PEND_HIGH,
    PEND_LOW,
    ABN_HIGH,
    ABN_LOW
  } state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntInc;
  logic [CW-1:0] hiCnt;
  logic [CW-1:0] loCnt;
  logic [EVT_W-1:0] evtNext;
  logic isHi;
  logic isLo;
  logic isSafe;
  logic pending;
  logic enterAbn;

  // Classify the sample and precompute the pending-count candidates.
  always_comb begin
    isHi = pressureData > HI_V;
    isLo = pressureData < LO_V;
    isSafe = (pressureData >= SAFE_LO) && (pressureData <= SAFE_HI);
    cntInc = cnt + CNT_ONE;
    hiCnt = (state == PEND_HIGH) ? cntInc : CNT_ONE;
    loCnt = (state == PEND_LOW) ? cntInc : CNT_ONE;
    pending = (state == NORMAL) || (state == PEND_HIGH) || (state == PEND_LOW);
    enterAbn = sampleValid && pending &&
               ((isHi && hiCnt == CNT_MAX) || (isLo && loCnt == CNT_MAX));
    evtNext = (eventCount == '1) ? eventCount : eventCount + EVT_W'(1);
  end

  // Persistence FSM and saturating episode counter.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= NORMAL;
      cnt <= '0;
      eventCount <= '0;
    end else if (sampleValid) begin
      unique case (state)
        NORMAL, PEND_HIGH, PEND_LOW: begin
          unique case (1'b1)
            isHi: begin
              if (hiCnt == CNT_MAX) begin
                state <= ABN_HIGH;
                cnt <= '0;
                eventCount <= evtNext;
              end else begin
                state <= PEND_HIGH;
                cnt <= hiCnt;
              end
            end
            isLo: begin
              if (loCnt == CNT_MAX) begin
                state <= ABN_LOW;
                cnt <= '0;
                eventCount <= evtNext;
              end else begin
                state <= PEND_LOW;
                cnt <= loCnt;
              end
            end
            default: begin
              state <= NORMAL;
              cnt <= '0;
            end
          endcase
        end
        ABN_HIGH: begin
          unique case (1'b1)
            isSafe: begin
              if (cntInc == CNT_MAX) begin
                state <= NORMAL;
                cnt <= '0;
              end else begin
                cnt <= cntInc;
              end
            end
            isLo: begin
              state <= ABN_LOW;
              cnt <= '0;
            end
            default: cnt <= '0;
          endcase
        end
        ABN_LOW: begin
          unique case (1'b1)
            isSafe: begin
              if (cntInc == CNT_MAX) begin
                state <= NORMAL;
                cnt <= '0;
              end else begin
                cnt <= cntInc;
              end
            end
            isHi: begin
              state <= ABN_HIGH;
              cnt <= '0;
            end
            default: cnt <= '0;
          endcase
        end
        default: begin
          state <= NORMAL;
          cnt <= '0;
        end
      endcase
    end
  end

  assign abnormalHigh = (state == ABN_HIGH);
  assign abnormalLow = (state == ABN_LOW);
  assign pressureAbnormality = abnormalHigh | abnormalLow;

`ifdef PRESSURE_ALARM_LATCH_EN
  logic latchQ;

  // Sticky alarm: entry beats a same-edge ack; ack only clears once recovered.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      latchQ <= 1'b0;
    end else if (enterAbn) begin
      latchQ <= 1'b1;
    end else if (alarmAck && !pressureAbnormality) begin
      latchQ <= 1'b0;
    end
  end

  assign alarmLatched = latchQ;
`else
  // Ack has no effect in this build; the alarm simply follows the state.
  assign alarmLatched = pressureAbnormality | (alarmAck & 1'b0) | (enterAbn & 1'b0);
`endif

endmodule

// File: tb/tb_pressure_abnormality_monitor.sv
// Directed bench for pressure_abnormality_monitor with a scoreboard queue.
// Expected values follow the default parameters and the active build.
module tb_pressure_abnormality_monitor;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [5:0] pressureData = '0;
  logic sampleValid = 1'b0;
  logic alarmAck = 1'b0;
  logic pressureAbnormality;
  logic abnormalHigh;
  logic abnormalLow;
  logic alarmLatched;
  logic [7:0] eventCount;

`ifdef PRESSURE_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  typedef struct {
    logic [11:0] v;
    string tag;
  } exp_t;

  exp_t sb[$];
  int nAssert = 0;
  int nFail = 0;

  pressure_abnormality_monitor dut (
    .clk(clk),
    .rstN(rstN),
    .pressureData(pressureData),
    .sampleValid(sampleValid),
    .alarmAck(alarmAck),
    .pressureAbnormality(pressureAbnormality),
    .abnormalHigh(abnormalHigh),
    .abnormalLow(abnormalLow),
    .alarmLatched(alarmLatched),
    .eventCount(eventCount)
  );

  always #5 clk = ~clk;

  task automatic step(
    input string tag,
    input logic r, input logic v, input logic [5:0] d, input logic a,
    input logic eHi, input logic eLo, input logic eLat, input logic [7:0] eEvt
  );
    exp_t e;
    exp_t got;
    logic [11:0] obs;
    logic lat;
    @(negedge clk);
    rstN = r;
    sampleValid = v;
    pressureData = d;
    alarmAck = a;
    lat = LATCH ? eLat : (eHi | eLo);
    e.v = {eHi | eLo, eHi, eLo, lat, eEvt};
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = {pressureAbnormality, abnormalHigh, abnormalLow, alarmLatched, eventCount};
    got = sb.pop_front();
    nAssert++;
    assert (obs === got.v) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", got.tag, obs, got.v);
    end
  endtask

  initial begin
    step("reset", 0, 0, 6'd0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) step("safe40", 1, 1, 6'd40, 0, 0, 0, 0, 8'd0);
    step("hi1", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("hi2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("hi3_enter", 1, 1, 6'd44, 0, 1, 0, 1, 8'd1);
    step("ack_abn", 1, 0, 6'd44, 1, 1, 0, 1, 8'd1);
    for (int i = 0; i < 3; i++) step("guard41", 1, 1, 6'd41, 0, 1, 0, 1, 8'd1);
    step("exit1", 1, 1, 6'd40, 0, 1, 0, 1, 8'd1);
    step("exit2", 1, 1, 6'd40, 0, 1, 0, 1, 8'd1);
    step("exit3", 1, 1, 6'd40, 0, 0, 0, 1, 8'd1);
    step("ack_clear", 1, 0, 6'd40, 1, 0, 0, 0, 8'd1);
    step("brk_hi1", 1, 1, 6'd44, 0, 0, 0, 0, 8'd1);
    step("brk_hi2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd1);
    step("brk_safe", 1, 1, 6'd40, 0, 0, 0, 0, 8'd1);
    step("gap_hi1", 1, 1, 6'd44, 0, 0, 0, 0, 8'd1);
    step("gap_a", 1, 0, 6'd44, 0, 0, 0, 0, 8'd1);
    step("gap_hi2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd1);
    step("gap_b", 1, 0, 6'd44, 0, 0, 0, 0, 8'd1);
    step("gap_hi3", 1, 1, 6'd44, 0, 1, 0, 1, 8'd2);
    step("flip_lo", 1, 1, 6'd0, 0, 0, 1, 1, 8'd2);
    step("rst_abnlo", 0, 1, 6'd0, 0, 0, 0, 0, 8'd0);
    step("p_hi1", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("p_hi2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("rst_pend", 0, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("fresh1", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("fresh2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd0);
    step("fresh3", 1, 1, 6'd44, 0, 1, 0, 1, 8'd1);
    step("flip_lo2", 1, 1, 6'd0, 0, 0, 1, 1, 8'd1);
    step("rst_abnlo2", 0, 0, 6'd0, 0, 0, 0, 0, 8'd0);
    step("edge42", 1, 1, 6'd42, 0, 0, 0, 0, 8'd0);
    step("edge8", 1, 1, 6'd8, 0, 0, 0, 0, 8'd0);
    step("lo7_1", 1, 1, 6'd7, 0, 0, 0, 0, 8'd0);
    step("lo7_2", 1, 1, 6'd7, 0, 0, 0, 0, 8'd0);
    step("lo7_3", 1, 1, 6'd7, 0, 0, 1, 1, 8'd1);
    step("flip_hi43", 1, 1, 6'd43, 0, 1, 0, 1, 8'd1);
    step("safe10", 1, 1, 6'd10, 0, 1, 0, 1, 8'd1);
    step("safe40b", 1, 1, 6'd40, 0, 1, 0, 1, 8'd1);
    step("safe10_exit", 1, 1, 6'd10, 0, 0, 0, 1, 8'd1);
    step("ack_valid", 1, 1, 6'd44, 1, 0, 0, 0, 8'd1);
    step("ack_p2", 1, 1, 6'd44, 0, 0, 0, 0, 8'd1);
    step("ack_enter", 1, 1, 6'd44, 1, 1, 0, 1, 8'd2);
    step("guard9", 1, 1, 6'd9, 0, 1, 0, 1, 8'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
